// File: rtl/fod_spi_pkg.sv
// Shared definitions for the FOD SPI register file: register map, reset map,
// control-field bundle and the field pack/unpack helpers used for both banks.
package fod_spi_pkg;

  localparam logic [3:0] ADDR_FCW_LO = 4'h0;
  localparam logic [3:0] ADDR_FCW_HI = 4'h1;
  localparam logic [3:0] ADDR_PCALI  = 4'h2;
  localparam logic [3:0] ADDR_PHASE  = 4'h3;
  localparam logic [3:0] ADDR_INLCAL = 4'h4;
  localparam logic [3:0] ADDR_KBCD   = 4'h5;
  localparam logic [3:0] ADDR_KDTCB  = 4'h6;
  localparam logic [3:0] ADDR_KDTCC  = 4'h7;
  localparam logic [3:0] ADDR_KDTCD  = 4'h8;
  localparam logic [3:0] ADDR_SYS    = 4'h9;
  localparam logic [3:0] ADDR_CMD    = 4'hA;
  localparam logic [3:0] ADDR_STATUS = 4'hB;
  localparam logic [3:0] ADDR_ID     = 4'hC;

  localparam logic [15:0] RST_FCW_LO = 16'hC000;
  localparam logic [15:0] RST_FCW_HI = 16'h0004;
  localparam logic [15:0] RST_PCALI  = 16'h0801;
  localparam logic [15:0] RST_PHASE  = 16'h0000;
  localparam logic [15:0] RST_INLCAL = 16'h0079;
  localparam logic [15:0] RST_KBCD   = 16'h6FA0;
  localparam logic [15:0] RST_KDTCB  = 16'd390;
  localparam logic [15:0] RST_KDTCC  = 16'd195;
  localparam logic [15:0] RST_KDTCD  = 16'd0;
  localparam logic [15:0] RST_SYS    = 16'h0006;
  localparam logic [9:0][15:0] RST_MAP = {RST_SYS, RST_KDTCD, RST_KDTCC, RST_KDTCB,
    RST_KBCD, RST_INLCAL, RST_PHASE, RST_PCALI, RST_FCW_HI, RST_FCW_LO};

  // Field bit positions inside their 16-bit registers
  localparam int B_PCALI_EN = 0, B_FREQ_C_EN = 1, B_FREQ_C_MODE = 2, B_FREQ_C_KS = 3;
  localparam int B_PCALI_KS = 8, B_PCALI_FD = 13;
  localparam int B_RT_EN = 0, B_DTCCALI_EN = 1, B_OFSTCALI_EN = 2, B_PSEG = 3, B_CALIORDER = 5;
  localparam int B_KB = 0, B_KC = 5, B_KD = 10;
  localparam int B_SYS_EN = 0, B_DSM_NRST = 1, B_NCO_NRST = 2;
  localparam int B_APPLY = 0, B_HOP = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_DONE} spi_state_t;

  typedef struct packed {
    logic [31:0] fcw;
    logic        pcali_en, freq_c_en, freq_c_mode;
    logic [4:0]  freq_c_ks, pcali_ks;
    logic [2:0]  pcali_freqdown;
    logic [9:0]  phase_ctrl;
    logic        rt_en, dtccali_en, ofstcali_en;
    logic [1:0]  pseg, caliorder;
    logic [4:0]  kb, kc, kd;
    logic [9:0]  kdtcb_init, kdtcc_init, kdtcd_init;
    logic        sys_en, dsm_sync_nrst_en, nco_sync_nrst_en;
  } fod_cfg_t;

  // FCW bits above WI+WF are forced to zero so they never hold state.
  function automatic fod_cfg_t cfg_wr(fod_cfg_t c, logic [3:0] a, logic [15:0] d,
                                      logic [31:0] fcw_mask);
    fod_cfg_t r = c;
    case (a)
      ADDR_FCW_LO: r.fcw[15:0]  = d;
      ADDR_FCW_HI: r.fcw[31:16] = d;
      ADDR_PCALI: begin
        r.pcali_en       = d[B_PCALI_EN];
        r.freq_c_en      = d[B_FREQ_C_EN];
        r.freq_c_mode    = d[B_FREQ_C_MODE];
        r.freq_c_ks      = d[B_FREQ_C_KS +: 5];
        r.pcali_ks       = d[B_PCALI_KS +: 5];
        r.pcali_freqdown = d[B_PCALI_FD +: 3];
      end
      ADDR_PHASE: r.phase_ctrl = d[9:0];
      ADDR_INLCAL: begin
        r.rt_en       = d[B_RT_EN];
        r.dtccali_en  = d[B_DTCCALI_EN];
        r.ofstcali_en = d[B_OFSTCALI_EN];
        r.pseg        = d[B_PSEG +: 2];
        r.caliorder   = d[B_CALIORDER +: 2];
      end
      ADDR_KBCD: begin
        r.kb = d[B_KB +: 5];
        r.kc = d[B_KC +: 5];
        r.kd = d[B_KD +: 5];
      end
      ADDR_KDTCB: r.kdtcb_init = d[9:0];
      ADDR_KDTCC: r.kdtcc_init = d[9:0];
      ADDR_KDTCD: r.kdtcd_init = d[9:0];
      ADDR_SYS: begin
        r.sys_en           = d[B_SYS_EN];
        r.dsm_sync_nrst_en = d[B_DSM_NRST];
        r.nco_sync_nrst_en = d[B_NCO_NRST];
      end
      default: ;
    endcase
    r.fcw = r.fcw & fcw_mask;
    return r;
  endfunction

  function automatic logic [15:0] cfg_rd(fod_cfg_t c, logic [3:0] a);
    case (a)
      ADDR_FCW_LO: return c.fcw[15:0];
      ADDR_FCW_HI: return c.fcw[31:16];
      ADDR_PCALI:  return {c.pcali_freqdown, c.pcali_ks, c.freq_c_ks,
                           c.freq_c_mode, c.freq_c_en, c.pcali_en};
      ADDR_PHASE:  return {6'd0, c.phase_ctrl};
      ADDR_INLCAL: return {9'd0, c.caliorder, c.pseg, c.ofstcali_en, c.dtccali_en, c.rt_en};
      ADDR_KBCD:   return {1'b0, c.kd, c.kc, c.kb};
      ADDR_KDTCB:  return {6'd0, c.kdtcb_init};
      ADDR_KDTCC:  return {6'd0, c.kdtcc_init};
      ADDR_KDTCD:  return {6'd0, c.kdtcd_init};
      ADDR_SYS:    return {13'd0, c.nco_sync_nrst_en, c.dsm_sync_nrst_en, c.sys_en};
      default:     return '0;
    endcase
  endfunction

  function automatic fod_cfg_t cfg_reset(logic [31:0] fcw_mask);
    fod_cfg_t c = '0;
    for (int i = 0; i <= int'(ADDR_SYS); i++) c = cfg_wr(c, 4'(i), RST_MAP[i], fcw_mask);
    return c;
  endfunction

endpackage

// File: rtl/fod_spi_slave.sv
// Oversampled mode-0 SPI slave: synchronisers, edge detect, 24-bit framing FSM.
// Strobes are combinational so the bank commit lands in the 24th-edge cycle.
module fod_spi_slave
  import fod_spi_pkg::*;
#(
  parameter int AW          = 7,
  parameter int DW          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          sclk,
  input  logic          csb,
  input  logic          mosi,
  input  logic [DW-1:0] rdata,
  output logic          wr_stb,
  output logic          rd_stb,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  output logic          miso,
  output logic          miso_oe
);
  localparam int CW    = 1 + AW;
  localparam int FRAME = CW + DW;
  localparam int CNT_W = $clog2(FRAME + 1);

  logic [SYNC_STAGES-1:0] sclk_q, csb_q, mosi_q;
  logic sclk_d, sclk_s, csb_s, mosi_s, rise, fall;

  // CSB synchroniser presets high so a reset never looks like a frame start
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sclk_q <= '0;
      csb_q  <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      csb_q  <= {csb_q[SYNC_STAGES-2:0], csb};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s;
    end
  end

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign csb_s  = csb_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d;
  assign fall   = ~sclk_s & sclk_d;

  spi_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    cmd_sr, addr_q;
  logic [DW-2:0]    dat_sr;
  logic [DW-1:0]    tx;
  logic             rnw;
  logic [CW-1:0]    cmd_nxt;
  logic             last_cmd, last_dat;

  assign cmd_nxt  = {cmd_sr, mosi_s};
  assign wdata    = {dat_sr, mosi_s};
  assign last_cmd = (state == ST_CMD) && rise && (cnt == CNT_W'(CW - 1));
  assign last_dat = (state == ST_DATA) && rise && (cnt == CNT_W'(FRAME - 1));
  assign rd_stb   = last_cmd & cmd_nxt[CW-1] & ~csb_s;
  assign wr_stb   = last_dat & ~rnw & ~csb_s;
  assign addr     = (state == ST_CMD) ? cmd_nxt[AW-1:0] : addr_q;
  assign miso     = miso_oe & tx[DW-1];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cmd_sr  <= '0;
      dat_sr  <= '0;
      addr_q  <= '0;
      tx      <= '0;
      rnw     <= 1'b0;
      miso_oe <= 1'b0;
    end else if (csb_s) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      miso_oe <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_CMD;
          cnt   <= '0;
        end
        ST_CMD: if (rise) begin
          cmd_sr <= cmd_nxt[AW-1:0];
          cnt    <= cnt + 1'b1;
          if (last_cmd) begin
            state  <= ST_DATA;
            addr_q <= cmd_nxt[AW-1:0];
            rnw    <= cmd_nxt[CW-1];
            if (cmd_nxt[CW-1]) begin
              tx      <= rdata;
              miso_oe <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (rise) begin
            dat_sr <= wdata[DW-2:0];
            cnt    <= cnt + 1'b1;
            if (last_dat) begin
              state   <= ST_DONE;
              miso_oe <= 1'b0;
            end
          // MSB must survive the fall right after the command byte
          end else if (fall && cnt > CNT_W'(CW)) begin
            tx <= {tx[DW-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fod_spi_regfile.sv
// FOD control register file: SPI-written shadow bank, atomically applied to the
// active bank that drives the FOD controller, NCO/DSM and calibration loops.
module fod_spi_regfile
  import fod_spi_pkg::*;
#(
  parameter int          WI          = 6,
  parameter int          WF          = 16,
  parameter int          AW          = 7,
  parameter int          DW          = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [DW-1:0] ID_VAL    = 16'hF0D1
) (
  input  logic             CLK,
  input  logic             NARST,
  input  logic             SCLK,
  input  logic             CSB,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_OE,
  input  logic             UPDATE,
  output logic [WI+WF-1:0] FCW_FOD,
  output logic             PCALI_EN,
  output logic             FREQ_C_EN,
  output logic             FREQ_C_MODE,
  output logic [4:0]       FREQ_C_KS,
  output logic [4:0]       PCALI_KS,
  output logic [2:0]       PCALI_FREQDOWN,
  output logic [9:0]       PHASE_CTRL,
  output logic             RT_EN,
  output logic             DTCCALI_EN,
  output logic             OFSTCALI_EN,
  output logic [1:0]       PSEG,
  output logic [1:0]       CALIORDER,
  output logic [4:0]       KB,
  output logic [4:0]       KC,
  output logic [4:0]       KD,
  output logic [9:0]       KDTCB_INIT,
  output logic [9:0]       KDTCC_INIT,
  output logic [9:0]       KDTCD_INIT,
  output logic             SYS_EN,
  output logic             DSM_SYNC_NRST_EN,
  output logic             NCO_SYNC_NRST_EN,
  output logic             FREQ_HOP,
  output logic             PENDING
);
  localparam logic [31:0] FCW_MASK = (WI + WF >= 32) ? '1 : ((32'd1 << (WI + WF)) - 32'd1);

  logic          wr_stb, rd_stb;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata, rd_mux;

  fod_spi_slave #(.AW(AW), .DW(DW), .SYNC_STAGES(SYNC_STAGES)) u_slave (
    .gclk(CLK), .grst_n(NARST), .sclk(SCLK), .csb(CSB), .mosi(MOSI),
    .rdata(rdata), .wr_stb(wr_stb), .rd_stb(rd_stb), .addr(addr), .wdata(wdata),
    .miso(MISO), .miso_oe(MISO_OE)
  );

  fod_cfg_t   shadow, active;
  logic       pend_q, hop_q;
  logic [3:0] a4;
  logic       a_ok, wr_data, wr_cmd, hop, apply;

  assign a4      = addr[3:0];
  assign a_ok    = (addr >> 4) == '0;
  assign wr_data = wr_stb & a_ok & (a4 <= ADDR_SYS);
  assign wr_cmd  = wr_stb & a_ok & (a4 == ADDR_CMD);
  assign hop     = wr_cmd & wdata[B_HOP];
  assign apply   = UPDATE | (wr_cmd & wdata[B_APPLY]) | hop;

  // A commit coinciding with apply lands in shadow only, so PENDING stays set
  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      shadow <= cfg_reset(FCW_MASK);
      active <= cfg_reset(FCW_MASK);
      pend_q <= 1'b0;
      hop_q  <= 1'b0;
    end else begin
      if (wr_data) shadow <= cfg_wr(shadow, a4, wdata[15:0], FCW_MASK);
      if (apply) active <= shadow;
      pend_q <= wr_data | (pend_q & ~apply);
      hop_q  <= hop;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (a_ok) begin
      case (a4)
        ADDR_STATUS: rd_mux = DW'(pend_q);
        ADDR_ID:     rd_mux = ID_VAL;
        default:     rd_mux = DW'(cfg_rd(shadow, a4));
      endcase
    end
  end
  assign rdata = rd_stb ? rd_mux : '0;

  assign FCW_FOD          = active.fcw[WI+WF-1:0];
  assign PCALI_EN         = active.pcali_en;
  assign FREQ_C_EN        = active.freq_c_en;
  assign FREQ_C_MODE      = active.freq_c_mode;
  assign FREQ_C_KS        = active.freq_c_ks;
  assign PCALI_KS         = active.pcali_ks;
  assign PCALI_FREQDOWN   = active.pcali_freqdown;
  assign PHASE_CTRL       = active.phase_ctrl;
  assign RT_EN            = active.rt_en;
  assign DTCCALI_EN       = active.dtccali_en;
  assign OFSTCALI_EN      = active.ofstcali_en;
  assign PSEG             = active.pseg;
  assign CALIORDER        = active.caliorder;
  assign KB               = active.kb;
  assign KC               = active.kc;
  assign KD               = active.kd;
  assign KDTCB_INIT       = active.kdtcb_init;
  assign KDTCC_INIT       = active.kdtcc_init;
  assign KDTCD_INIT       = active.kdtcd_init;
  assign SYS_EN           = active.sys_en;
  assign DSM_SYNC_NRST_EN = active.dsm_sync_nrst_en;
  assign NCO_SYNC_NRST_EN = active.nco_sync_nrst_en;
  assign FREQ_HOP         = hop_q;
  assign PENDING          = pend_q;

endmodule

// File: tb/tb_fod_spi_regfile.sv
// Directed + random bench for fod_spi_regfile against a register-word model.
`timescale 1ns/1ps
module tb_fod_spi_regfile;
  localparam int H = 5;  // SCLK half period in CLK cycles

  logic CLK = 0, NARST = 0, SCLK = 0, CSB = 1, MOSI = 0, UPDATE = 0;
  logic MISO, MISO_OE, FREQ_HOP, PENDING;
  logic [21:0] FCW_FOD;
  logic PCALI_EN, FREQ_C_EN, FREQ_C_MODE, RT_EN, DTCCALI_EN, OFSTCALI_EN;
  logic [4:0] FREQ_C_KS, PCALI_KS, KB, KC, KD;
  logic [2:0] PCALI_FREQDOWN;
  logic [9:0] PHASE_CTRL, KDTCB_INIT, KDTCC_INIT, KDTCD_INIT;
  logic [1:0] PSEG, CALIORDER;
  logic SYS_EN, DSM_SYNC_NRST_EN, NCO_SYNC_NRST_EN;

  always #5 CLK = ~CLK;

  fod_spi_regfile dut (
    .CLK(CLK), .NARST(NARST), .SCLK(SCLK), .CSB(CSB), .MOSI(MOSI), .MISO(MISO),
    .MISO_OE(MISO_OE), .UPDATE(UPDATE), .FCW_FOD(FCW_FOD), .PCALI_EN(PCALI_EN),
    .FREQ_C_EN(FREQ_C_EN), .FREQ_C_MODE(FREQ_C_MODE), .FREQ_C_KS(FREQ_C_KS),
    .PCALI_KS(PCALI_KS), .PCALI_FREQDOWN(PCALI_FREQDOWN), .PHASE_CTRL(PHASE_CTRL),
    .RT_EN(RT_EN), .DTCCALI_EN(DTCCALI_EN), .OFSTCALI_EN(OFSTCALI_EN), .PSEG(PSEG),
    .CALIORDER(CALIORDER), .KB(KB), .KC(KC), .KD(KD), .KDTCB_INIT(KDTCB_INIT),
    .KDTCC_INIT(KDTCC_INIT), .KDTCD_INIT(KDTCD_INIT), .SYS_EN(SYS_EN),
    .DSM_SYNC_NRST_EN(DSM_SYNC_NRST_EN), .NCO_SYNC_NRST_EN(NCO_SYNC_NRST_EN),
    .FREQ_HOP(FREQ_HOP), .PENDING(PENDING)
  );

  int total = 0, bad = 0;
  logic [15:0] sh [0:9];
  logic [15:0] ac [0:9];
  bit pend;

  // Hop monitor: counts pulses and records whether KDTCB_INIT changed in that CLK
  int hop_cnt = 0;
  bit hop_new;
  logic [9:0] kdtcb_prev = '0;
  always @(negedge CLK) begin
    if (FREQ_HOP === 1'b1) begin
      hop_cnt++;
      hop_new = (KDTCB_INIT == 10'd1023) && (kdtcb_prev != 10'd1023);
    end
    kdtcb_prev = KDTCB_INIT;
  end

  function automatic logic [15:0] msk(int a);
    case (a)
      0, 2:    return 16'hFFFF;
      1:       return 16'h003F;
      3, 6, 7, 8: return 16'h03FF;
      4:       return 16'h007F;
      5:       return 16'h7FFF;
      9:       return 16'h0007;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    logic [15:0] rv [0:9];
    rv = '{16'hC000, 16'h0004, 16'h0801, 16'h0000, 16'h0079, 16'h6FA0,
           16'd390, 16'd195, 16'd0, 16'h0006};
    for (int i = 0; i < 10; i++) begin sh[i] = rv[i]; ac[i] = rv[i]; end
    pend = 0;
  endtask

  task automatic model_apply();
    for (int i = 0; i < 10; i++) ac[i] = sh[i];
    pend = 0;
  endtask

  // upd: UPDATE coincided with this commit (apply sees the old shadow)
  task automatic model_write(input int a, input logic [15:0] d, input bit upd);
    if (upd || (a == 10 && d[1:0] != 2'b00)) model_apply();
    if (a <= 9) begin sh[a] = d & msk(a); pend = 1; end
  endtask

  function automatic logic [15:0] model_read(int a);
    if (a <= 9) return sh[a];
    if (a == 11) return {15'd0, pend};
    if (a == 12) return 16'hF0D1;
    return 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".fcw"}, 32'(FCW_FOD), 32'({ac[1][5:0], ac[0]}));
    chk({tag, ".r02"}, 32'({PCALI_FREQDOWN, PCALI_KS, FREQ_C_KS, FREQ_C_MODE, FREQ_C_EN, PCALI_EN}), 32'(ac[2]));
    chk({tag, ".phase"}, 32'(PHASE_CTRL), 32'(ac[3]));
    chk({tag, ".r04"}, 32'({CALIORDER, PSEG, OFSTCALI_EN, DTCCALI_EN, RT_EN}), 32'(ac[4]));
    chk({tag, ".r05"}, 32'({KD, KC, KB}), 32'(ac[5]));
    chk({tag, ".kdtc"}, {2'b0, KDTCB_INIT, KDTCC_INIT, KDTCD_INIT}, {2'b0, ac[6][9:0], ac[7][9:0], ac[8][9:0]});
    chk({tag, ".r09"}, 32'({NCO_SYNC_NRST_EN, DSM_SYNC_NRST_EN, SYS_EN}), 32'(ac[9]));
    chk({tag, ".pending"}, 32'(PENDING), 32'(pend));
    chk({tag, ".miso_oe_idle"}, 32'({MISO_OE, MISO}), 32'd0);
  endtask

  // Master drives on SCLK low, samples MISO just before each rising edge
  task automatic spi(input bit rw, input int a, input logic [15:0] d, input int nbits,
                     input bit upd_last, output logic [15:0] rd, output bit oe_cmd, output bit oe_dat);
    logic [23:0] fr;
    fr = {rw, 7'(a), d};
    rd = '0; oe_cmd = 0; oe_dat = 1;
    @(negedge CLK); CSB = 0;
    repeat (4) @(negedge CLK);
    for (int i = 0; i < nbits; i++) begin
      MOSI = fr[23-i];
      repeat (H) @(negedge CLK);
      if (i < 8) oe_cmd |= MISO_OE;
      else begin oe_dat &= MISO_OE; rd = {rd[14:0], MISO}; end
      SCLK = 1;
      if (upd_last && i == nbits - 1) begin
        // two sync flops then the edge-detect cycle is the commit cycle
        @(posedge CLK); @(posedge CLK); @(negedge CLK); UPDATE = 1;
        @(negedge CLK); UPDATE = 0;
        repeat (H - 3) @(negedge CLK);
      end else repeat (H) @(negedge CLK);
      SCLK = 0;
    end
    repeat (H) @(negedge CLK);
    CSB = 1;
    repeat (6) @(negedge CLK);
  endtask

  task automatic wr(input int a, input logic [15:0] d, input bit upd);
    logic [15:0] r; bit oc, od;
    spi(0, a, d, 24, upd, r, oc, od);
    model_write(a, d, upd);
  endtask

  task automatic rd_chk(input string tag, input int a);
    logic [15:0] r; bit oc, od;
    spi(1, a, 16'h0, 24, 0, r, oc, od);
    chk({tag, ".data"}, 32'(r), 32'(model_read(a)));
    chk({tag, ".oe"}, {30'd0, oc, od}, 32'b01);
  endtask

  task automatic pulse_update();
    @(negedge CLK); UPDATE = 1;
    @(negedge CLK); UPDATE = 0;
    model_apply();
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int h0, a, ra;
    logic [15:0] d, r;
    bit oc, od;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("in_reset.miso", 32'({MISO_OE, MISO, FREQ_HOP, PENDING}), 32'd0);
    NARST = 1;
    repeat (3) @(negedge CLK);
    chk("rst.fcw", 32'(FCW_FOD), 32'h4C000);
    chk("rst.pcali_ks", 32'(PCALI_KS), 32'd8);
    chk("rst.pseg", 32'(PSEG), 32'd3);
    chk("rst.kc", 32'(KC), 32'b11101);
    chk("rst.kdtcb", 32'(KDTCB_INIT), 32'd390);
    chk("rst.sys_en", 32'(SYS_EN), 32'd0);
    check_outputs("rst");

    // FCW staged then applied through CMD.APPLY
    h0 = hop_cnt;
    wr(0, 16'h8000, 0);
    wr(1, 16'h0005, 0);
    check_outputs("fcw_staged");
    chk("fcw_staged.pend", 32'(PENDING), 32'd1);
    wr(10, 16'h0001, 0);
    chk("apply.fcw", 32'(FCW_FOD), 32'h58000);
    check_outputs("apply");
    chk("apply.nohop", 32'(hop_cnt - h0), 32'd0);

    rd_chk("rd_id", 12);
    rd_chk("rd_kbcd", 5);
    rd_chk("rd_status", 11);

    // Hop: single FREQ_HOP pulse coincident with the new active value
    h0 = hop_cnt;
    wr(6, 16'h03FF, 0);
    wr(10, 16'h0002, 0);
    chk("hop.count", 32'(hop_cnt - h0), 32'd1);
    chk("hop.coincident", 32'(hop_new), 32'd1);
    chk("hop.kdtcb", 32'(KDTCB_INIT), 32'd1023);
    check_outputs("hop");

    // Aborted frame after 15 bits: no write, next frame decodes normally
    spi(0, 3, 16'h02AA, 15, 0, r, oc, od);
    chk("abort.oe", 32'(MISO_OE), 32'd0);
    rd_chk("abort.rd3", 3);
    rd_chk("abort.rd6", 6);
    check_outputs("abort");

    // UPDATE in the commit cycle applies the pre-commit shadow
    wr(3, 16'h0155, 1);
    chk("upd_coin.phase", 32'(PHASE_CTRL), 32'd0);
    chk("upd_coin.pend", 32'(PENDING), 32'd1);
    check_outputs("upd_coin");
    pulse_update();
    chk("upd2.phase", 32'(PHASE_CTRL), 32'h155);
    check_outputs("upd2");

    // CMD.APPLY together with UPDATE: one apply, no hop
    h0 = hop_cnt;
    wr(9, 16'h0001, 0);
    wr(10, 16'h0001, 1);
    check_outputs("cmd_upd");
    chk("cmd_upd.nohop", 32'(hop_cnt - h0), 32'd0);

    // Unmapped write is ignored
    wr($urandom_range(13, 127), 16'hFFFF, 0);
    check_outputs("unmapped_wr");

    for (int it = 0; it < 8; it++) begin
      a = $urandom_range(0, 9);
      d = 16'($urandom);
      wr(a, d, 0);
      if ($urandom_range(0, 1) == 1) pulse_update();
      ra = $urandom_range(0, 15);
      if (ra > 12) ra = $urandom_range(13, 127);
      rd_chk("rnd.rd", ra);
      rd_chk("rnd.rdw", a);
      check_outputs("rnd");
    end

    // Reset in the middle of a frame
    wr(3, 16'h0123, 0);
    @(negedge CLK); CSB = 0; MOSI = 1;
    repeat (4) @(negedge CLK); SCLK = 1;
    repeat (4) @(negedge CLK); NARST = 0;
    repeat (2) @(negedge CLK);
    SCLK = 0; CSB = 1; MOSI = 0;
    repeat (2) @(negedge CLK); NARST = 1;
    model_reset();
    repeat (4) @(negedge CLK);
    check_outputs("midreset");
    rd_chk("midreset.rd3", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
